lossless_block_decoder: RTL
===========================

Name: lossless_block_decoder

Overview:
- Stage directly upstream of the IDCT stage (Milestone 2).
- Reads a compressed bitstream from external SRAM through the top-level SRAM mux.
- Decodes prefix codes into 64-coefficient blocks, emitted in scan order over a valid/ready stream.
- The top-level FSM starts it before Milestone 2 and gives it SRAM ownership while running.

Parameters:
- BITSTREAM_BASE, 18'd76800, SRAM word address of the header word.
- NUM_BLOCKS, 2400, blocks to decode per run (1200 Y + 600 U + 600 V).
- HEADER_WORD, 16'hDEAD, required value of the first bitstream word.

Ports:
- Clock_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- M3_start  in  1  level; decoding begins on the first cycle it is seen high in S_IDLE.
- SRAM_read_data  in  16  data for the address presented 2 cycles earlier.
- SRAM_address_O  out  18  read address.
- SRAM_we_n  out  1  constant 1; the block is read-only.
- SRAM_write_data  out  16  constant 0.
- coeff_valid  out  1  coefficient available.
- coeff_ready  in  1  consumer accepts while valid is high.
- coeff_data  out  16  signed coefficient.
- coeff_index  out  6  scan position 0..63.
- block_last  out  1  high with index 63.
- decode_error  out  1  sticky header-mismatch flag.
- M3_finished  out  1  one-cycle done pulse.

Behaviour:
- Reset (async, any state): FSM to S_IDLE. All outputs 0 except SRAM_we_n=1 and SRAM_address_O=BITSTREAM_BASE. Bit buffer, counters and in-flight reads are discarded.
- S_IDLE: on M3_start, go to S_HEADER and clear decode_error.
- S_HEADER: read BITSTREAM_BASE.
  - Word equal to HEADER_WORD: go to S_DECODE, next read address BITSTREAM_BASE+1.
  - Otherwise: set decode_error, go to S_DONE.
- Bit buffer: 32 bits, MSB-first, with a 6-bit valid count.
  - A read is issued when valid ≤ 16 and no read is in flight.
  - The returned word is appended below the existing valid bits; address increments by 1.
  - At most one outstanding read.
- S_DECODE: one token per cycle, decoded only when valid ≥ 9 and no coefficient is pending. Otherwise it stalls.
  - Code '00'+3b: signed literal -4..3; consumes 5 bits.
  - Code '01'+6b: signed literal -32..31; consumes 8 bits.
  - Code '10'+3b: zero run of length 1..8 (field 000 = 8); go to S_RUN.
  - Code '11': zeros to end of block; go to S_FILL.
  - Literals are sign-extended to 16 bits.
- S_RUN and S_FILL: one zero presented per accepted transfer.
  - S_RUN returns to S_DECODE when the run is exhausted.
  - S_FILL returns when index 63 is accepted.
  - A '11' token at index 0 produces 64 zeros.
- Handshake:
  - A transfer occurs on a cycle with coeff_valid & coeff_ready.
  - coeff_data, coeff_index and block_last stay stable while valid is high and ready is low.
  - valid never drops without a transfer.
  - Back-to-back transfers sustain 1 per cycle whenever the buffer allows.
- Index wrap:
  - coeff_index increments per transfer and wraps from 63 to 0; the block counter increments on that wrap.
  - A run crossing index 63 is truncated at 63; the remainder is discarded and the next token starts the new block.
- Completion:
  - When the transfer with block_last for block NUM_BLOCKS-1 occurs, go to S_DONE.
  - Trailing bits and any in-flight read are ignored.
- S_DONE: M3_finished=1 for exactly one cycle, then S_IDLE. M3_start must be deasserted before restart; a still-high start is ignored for one cycle.

Optional Feature:
- Macro: LBD_DEQUANT_EN.
- Defined: coeff_data = sign-extended literal << (2 + coeff_index[5:4]), giving shift 2..5; result wraps in 16 bits. Zeros are unaffected.
- Undefined: coeff_data = sign-extended literal, unmodified.

Test Plan:
- Header mismatch: word0=16'h1234 → decode_error=1, no coeff_valid, M3_finished single pulse, return to S_IDLE.
- NUM_BLOCKS=1, words 16'hDEAD,16'h1E00 → coeff 3 at index 0, zeros at indices 1..63, block_last only at index 63, M3_finished one cycle after that transfer.
- Words 16'hDEAD,16'h60C0 → index 0 = 16'hFFE0 (-32), then 63 zeros.
- Token '10'+'000' then '11' (word 16'h83xx-style) with coeff_ready low for 5 cycles at index 4 → 8 zeros at 0..7, outputs held during stall, then fill to 63.
- Run of 8 starting at index 60 → only indices 60..63 emitted; the next literal appears at block 1 index 0.
- With LBD_DEQUANT_EN, literal 3 at index 0 → 12; literal 3 at index 48 → 96.
- Reset asserted mid-run → all outputs at reset values on the same edge, S_IDLE; a fresh start decodes the stream from the header.

Source files
------------

// File: rtl/lossless_block_decoder.sv
// Prefix-code bitstream decoder: reads SRAM words into a 32-bit bit buffer and emits 64-coefficient blocks in scan order.
// Coefficients use a registered valid/ready output (one per cycle when bits allow); LBD_DEQUANT_EN scales literals by 2^(2+index[5:4]).
module lossless_block_decoder #(
    parameter logic [17:0] BITSTREAM_BASE = 18'd76800,
    parameter int          NUM_BLOCKS     = 2400,
    parameter logic [15:0] HEADER_WORD    = 16'hDEAD
) (
    input  logic        Clock_50,
    input  logic        reset,
    input  logic        M3_start,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address_O,
    output logic        SRAM_we_n,
    output logic [15:0] SRAM_write_data,
    output logic        coeff_valid,
    input  logic        coeff_ready,
    output logic [15:0] coeff_data,
    output logic [5:0]  coeff_index,
    output logic        block_last,
    output logic        decode_error,
    output logic        M3_finished
);
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DECODE, S_RUN, S_FILL, S_DONE} state_t;

    state_t        state;
    logic [31:0]   bit_buf;
    logic [5:0]    bit_cnt;
    logic          rd_req;
    logic          rd_p1;
    logic          rd_p2;
    logic [5:0]    next_idx;
    logic [2:0]    run_left;
    logic [BW-1:0] blk_cnt;

    logic        in_flight;
    logic        xfer;
    logic        out_free;
    logic        streaming;
    logic        last_xfer;
    logic        can_decode;
    logic        load_en;
    logic [1:0]  code;
    logic [3:0]  run_len;
    logic [5:0]  consume;
    logic [15:0] lit;
    logic [15:0] lit_out;
    logic [15:0] load_dat;
    logic [31:0] buf_next;
    logic [5:0]  cnt_next;

    assign SRAM_we_n       = 1'b1;
    assign SRAM_write_data = 16'h0000;

    assign in_flight  = rd_req | rd_p1 | rd_p2;
    assign xfer       = coeff_valid & coeff_ready;
    assign out_free   = ~coeff_valid | coeff_ready;
    assign streaming  = (state == S_DECODE) | (state == S_RUN) | (state == S_FILL);
    assign last_xfer  = xfer & block_last & (blk_cnt == BW'(NUM_BLOCKS - 1));
    assign can_decode = (state == S_DECODE) & ~last_xfer & out_free & (bit_cnt >= 6'd9);
    assign code       = bit_buf[31:30];

    always_comb begin
        lit     = 16'h0000;
        run_len = 4'd0;
        consume = 6'd0;
        case (code)
            2'b00: begin
                lit     = {{13{bit_buf[29]}}, bit_buf[29:27]};
                consume = 6'd5;
            end
            2'b01: begin
                lit     = {{10{bit_buf[29]}}, bit_buf[29:24]};
                consume = 6'd8;
            end
            2'b10: begin
                run_len = (bit_buf[29:27] == 3'd0) ? 4'd8 : {1'b0, bit_buf[29:27]};
                consume = 6'd5;
            end
            default: consume = 6'd2;
        endcase
        if (!can_decode) begin
            consume = 6'd0;
        end
    end

`ifdef LBD_DEQUANT_EN
    assign lit_out = lit << (3'd2 + {1'b0, next_idx[5:4]});
`else
    assign lit_out = lit;
`endif

    // Zeros from runs and fills share the output register with literals.
    assign load_en  = can_decode | (((state == S_RUN) | (state == S_FILL)) & out_free);
    assign load_dat = (can_decode & ~code[1]) ? lit_out : 16'h0000;

    // The returned word lands directly below the bits left after this cycle's token.
    always_comb begin
        cnt_next = bit_cnt - consume;
        buf_next = bit_buf << consume;
        if (rd_p2) begin
            buf_next = buf_next | ({SRAM_read_data, 16'h0000} >> cnt_next);
            cnt_next = cnt_next + 6'd16;
        end
    end

    always_ff @(posedge Clock_50 or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            bit_buf        <= 32'h0;
            bit_cnt        <= 6'd0;
            rd_req         <= 1'b0;
            rd_p1          <= 1'b0;
            rd_p2          <= 1'b0;
            SRAM_address_O <= BITSTREAM_BASE;
            next_idx       <= 6'd0;
            run_left       <= 3'd0;
            blk_cnt        <= '0;
            coeff_valid    <= 1'b0;
            coeff_data     <= 16'h0000;
            coeff_index    <= 6'd0;
            block_last     <= 1'b0;
            decode_error   <= 1'b0;
            M3_finished    <= 1'b0;
        end else begin
            rd_req      <= 1'b0;
            rd_p1       <= rd_req;
            rd_p2       <= rd_p1;
            M3_finished <= 1'b0;

            if (xfer) begin
                coeff_valid <= 1'b0;
                if (block_last) begin
                    blk_cnt <= blk_cnt + BW'(1);
                end
            end
            if (load_en) begin
                coeff_valid <= 1'b1;
                coeff_data  <= load_dat;
                coeff_index <= next_idx;
                block_last  <= (next_idx == 6'd63);
                next_idx    <= next_idx + 6'd1;
            end

            if (streaming) begin
                bit_buf <= buf_next;
                bit_cnt <= cnt_next;
                if (rd_p2) begin
                    SRAM_address_O <= SRAM_address_O + 18'd1;
                end
                if (!in_flight && bit_cnt <= 6'd16) begin
                    rd_req <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (M3_start) begin
                        state          <= S_HEADER;
                        decode_error   <= 1'b0;
                        SRAM_address_O <= BITSTREAM_BASE;
                        rd_req         <= 1'b1;
                        rd_p1          <= 1'b0;
                        rd_p2          <= 1'b0;
                        bit_buf        <= 32'h0;
                        bit_cnt        <= 6'd0;
                        next_idx       <= 6'd0;
                        run_left       <= 3'd0;
                        blk_cnt        <= '0;
                    end
                end
                S_HEADER: begin
                    if (rd_p2) begin
                        if (SRAM_read_data == HEADER_WORD) begin
                            state          <= S_DECODE;
                            SRAM_address_O <= SRAM_address_O + 18'd1;
                        end else begin
                            decode_error <= 1'b1;
                            M3_finished  <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                end
                S_DECODE: begin
                    if (last_xfer) begin
                        M3_finished <= 1'b1;
                        state       <= S_DONE;
                    end else if (can_decode) begin
                        // A run or fill that starts at index 63 is already complete.
                        if (code == 2'b10 && run_len != 4'd1 && next_idx != 6'd63) begin
                            run_left <= 3'(run_len - 4'd1);
                            state    <= S_RUN;
                        end
                        if (code == 2'b11 && next_idx != 6'd63) begin
                            state <= S_FILL;
                        end
                    end
                end
                S_RUN: begin
                    if (out_free) begin
                        run_left <= run_left - 3'd1;
                        if (run_left == 3'd1 || next_idx == 6'd63) begin
                            state <= S_DECODE;
                        end
                    end
                end
                S_FILL: begin
                    if (out_free && next_idx == 6'd63) begin
                        state <= S_DECODE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
